// File: rtl/tpu_seq.sv
// Command sequencer for a DIM x DIM systolic MAC array: optional accumulator
// clear, skewed operand-lane enables during compute, then a row-by-row readout.
module tpu_seq #(
  parameter int DIM    = 8,
  parameter int K_W    = 8,
  parameter int STEP_W = $clog2((1 << K_W) + 2 * DIM),
  parameter int ROW_W  = $clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic              clear_c,
  input  logic              feed_stall,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              mac_en,
  output logic              c_wr_en,
  output logic [ROW_W-1:0]  c_row,
  output logic [STEP_W-1:0] step,
  output logic [DIM-1:0]    a_lane_valid,
  output logic [DIM-1:0]    b_lane_valid,
  output logic              rd_valid,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_len_q, k_len_d;
  logic               clear_q, clear_d;
  logic [ROW_W-1:0]   c_row_q, c_row_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [DIM-1:0]     lane_q, lane_d;
  logic [K_W-1:0]     k_sel;
  logic [STEP_W-1:0]  last_step;

  // Final compute step is L-1 = k_len + 2*DIM - 3.
  assign last_step = STEP_W'(k_len_q) + STEP_W'(2 * DIM - 3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_len_q <= '0;
      clear_q <= 1'b0;
      c_row_q <= '0;
      step_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      clear_q <= clear_d;
      c_row_q <= c_row_d;
      step_q  <= step_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    clear_d = clear_q;
    c_row_d = c_row_q;
    step_d  = step_q;
    k_sel   = k_len_q;
    lane_d  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          k_len_d = k_len;
          clear_d = clear_c;
          k_sel   = k_len;
          step_d  = '0;
          c_row_d = '0;
          if (clear_c)            state_d = CLEAR;
          else if (k_len != '0)   state_d = COMPUTE;
          else                    state_d = DRAIN;
        end
      end
      CLEAR: begin
        if (c_row_q == ROW_W'(DIM - 1)) begin
          c_row_d = '0;
          state_d = (k_len_q != '0) ? COMPUTE : DRAIN;
        end else begin
          c_row_d = c_row_q + 1'b1;
        end
      end
      COMPUTE: begin
        if (!feed_stall) begin
          if (step_q == last_step) begin
            step_d  = '0;
            state_d = DRAIN;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (rd_ready) begin
          if (c_row_q == ROW_W'(DIM - 1)) begin
            c_row_d = '0;
            state_d = DONE;
          end else begin
            c_row_d = c_row_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Lane i is live while step falls in [i, i+k_len); a stall keeps step_d, so flags hold.
    if (state_d == COMPUTE) begin
      for (int i = 0; i < DIM; i++) begin
        lane_d[i] = (int'(step_d) >= i) && (int'(step_d) < i + int'(k_sel));
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign mac_en       = (state_q == COMPUTE) && !feed_stall;
  assign c_wr_en      = (state_q == CLEAR);
  assign rd_valid     = (state_q == DRAIN);
  assign c_row        = c_row_q;
  assign step         = step_q;
  assign a_lane_valid = lane_q;
  assign b_lane_valid = lane_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_tpu_seq.sv
// Bench for tpu_seq: table of commands run against a cycle-level reference,
// with a row scoreboard on the readout handshake.
module tb_tpu_seq;
  localparam int DIM    = 8;
  localparam int K_W    = 8;
  localparam int STEP_W = $clog2((1 << K_W) + 2 * DIM);
  localparam int ROW_W  = $clog2(DIM);
  localparam int NV     = 12;

  logic              clk = 1'b0;
  logic              rst, start, clear_c, feed_stall, rd_ready;
  logic [K_W-1:0]    k_len;
  logic              busy, done, mac_en, c_wr_en, rd_valid;
  logic [ROW_W-1:0]  c_row;
  logic [STEP_W-1:0] step;
  logic [DIM-1:0]    a_lane_valid, b_lane_valid;
  logic [2:0]        state_dbg;

  tpu_seq #(.DIM(DIM), .K_W(K_W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .clear_c(clear_c),
    .feed_stall(feed_stall), .rd_ready(rd_ready), .busy(busy), .done(done),
    .mac_en(mac_en), .c_wr_en(c_wr_en), .c_row(c_row), .step(step),
    .a_lane_valid(a_lane_valid), .b_lane_valid(b_lane_valid),
    .rd_valid(rd_valid), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    bit clr;
    int stall_at;
    int stall_len;
    int rdy_row;
    int rdy_len;
    int inj_step;
    int rst_step;
    int exp_done;
  } vec_t;

  vec_t vecs[NV];
  int checks = 0;
  int errors = 0;
  logic [ROW_W-1:0] exp_q[$];

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DIM-1:0] lanes(input int st, input int k);
    logic [DIM-1:0] r;
    for (int i = 0; i < DIM; i++) r[i] = (st >= i) && (st < i + k);
    return r;
  endfunction

  function automatic logic [63:0] observed();
    return 64'({state_dbg, busy, done, mac_en, c_wr_en, rd_valid, c_row, step,
                a_lane_valid, b_lane_valid});
  endfunction

  // Caller must be inside an IDLE cycle, after the negedge.
  task automatic run_cmd(input vec_t v, input int idx);
    int ph, cnt, st, row, stl, rdl, cyc, done_cyc, len;
    bit fs, rr, injected, do_rst, aborted;
    logic [ROW_W-1:0] e_row, got_row;
    logic [STEP_W-1:0] e_step;
    logic [DIM-1:0] e_lane;
    logic [63:0] e_vec;
    k_len = K_W'(v.k); clear_c = v.clr; start = 1'b1;
    feed_stall = 1'b0; rd_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k_len = K_W'($urandom_range(0, 255));
    clear_c = 1'($urandom_range(0, 1));
    for (int r = 0; r < DIM; r++) exp_q.push_back(ROW_W'(r));
    ph = v.clr ? 1 : (v.k != 0 ? 2 : 3);
    cnt = 0; st = 0; row = 0; stl = v.stall_len; rdl = v.rdy_len;
    len = v.k + 2 * DIM - 2; done_cyc = -1; cyc = 0;
    injected = 0; aborted = 0;
    forever begin
      cyc++;
      if (cyc > 600) begin
        check_val("cmd_timeout", 64'(cyc), 64'(600));
        break;
      end
      @(negedge clk);
      fs = (ph == 2) && (st == v.stall_at) && (stl > 0);
      rr = !((ph == 3) && (row == v.rdy_row) && (rdl > 0));
      feed_stall = fs; rd_ready = rr; start = 1'b0; do_rst = 0;
      if (ph == 2 && !fs && st == v.inj_step && !injected) begin
        start = 1'b1; k_len = K_W'(200); injected = 1;
      end
      if (ph == 2 && !fs && st == v.rst_step) begin
        rst = 1'b1; do_rst = 1;
      end
      #1;
      e_row  = (ph == 1) ? ROW_W'(cnt) : (ph == 3) ? ROW_W'(row) : '0;
      e_step = (ph == 2) ? STEP_W'(st) : '0;
      e_lane = (ph == 2) ? lanes(st, v.k) : '0;
      e_vec = 64'({3'(ph), ph != 0, ph == 4, ph == 2 && !fs, ph == 1, ph == 3,
                   e_row, e_step, e_lane, e_lane});
      check_val($sformatf("outputs v%0d c%0d", idx, cyc), observed(), e_vec);
      if (rd_valid && rd_ready) begin
        got_row = c_row;
        if (exp_q.size() == 0) begin
          check_val("rd_row_extra", 64'(got_row), 64'hFFFF);
        end else begin
          check_val("rd_row", 64'(got_row), 64'(exp_q.pop_front()));
        end
      end
      if (done) done_cyc = cyc;
      if (ph == 0) begin
        rst = 1'b0;
        break;
      end
      if (do_rst) begin
        ph = 0; aborted = 1;
      end else begin
        case (ph)
          1: begin
            cnt++;
            if (cnt == DIM) begin cnt = 0; ph = (v.k != 0) ? 2 : 3; end
          end
          2: begin
            if (fs) stl--;
            else if (st == len - 1) begin st = 0; ph = 3; end
            else st++;
          end
          3: begin
            if (!rr) rdl--;
            else if (row == DIM - 1) begin row = 0; ph = 4; end
            else row++;
          end
          default: ph = 0;
        endcase
      end
      @(posedge clk);
    end
    check_val($sformatf("done_cycle v%0d", idx), 64'(done_cyc), 64'(v.exp_done));
    if (aborted) exp_q.delete();
    else check_val("rows_left", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    //            k    clr stall_at len rdy_row len inj  rst  done
    vecs[0]  = '{3,   1, -1, 0, -1, 0, -1, -1, 34};
    vecs[1]  = '{3,   1,  5, 4, -1, 0, -1, -1, 38};
    vecs[2]  = '{0,   0, -1, 0, -1, 0, -1, -1, 9};
    vecs[3]  = '{0,   1, -1, 0, -1, 0, -1, -1, 17};
    vecs[4]  = '{5,   0, -1, 0,  2, 3, -1, -1, 31};
    vecs[5]  = '{3,   0, -1, 0, -1, 0,  2, -1, 26};
    vecs[6]  = '{255, 0, -1, 0, -1, 0, -1, -1, 278};
    vecs[7]  = '{1,   1, -1, 0, -1, 0, -1, -1, 32};
    vecs[8]  = '{4,   0, -1, 0, -1, 0, -1,  4, -1};
    vecs[9]  = '{2,   0, -1, 0, -1, 0, -1, -1, 25};
    for (int n = 10; n < NV; n++) begin
      vecs[n].k = $urandom_range(1, 60);
      vecs[n].clr = 1'($urandom_range(0, 1));
      vecs[n].stall_at = $urandom_range(0, vecs[n].k + 2 * DIM - 3);
      vecs[n].stall_len = $urandom_range(1, 5);
      vecs[n].rdy_row = $urandom_range(0, DIM - 1);
      vecs[n].rdy_len = $urandom_range(0, 4);
      vecs[n].inj_step = -1;
      vecs[n].rst_step = -1;
      vecs[n].exp_done = vecs[n].clr * DIM + vecs[n].k + 2 * DIM - 2 + vecs[n].stall_len
                         + DIM + 1 + vecs[n].rdy_len;
    end

    rst = 1'b1; start = 1'b0; k_len = '0; clear_c = 1'b0;
    feed_stall = 1'b0; rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    #1;
    check_val("reset_outputs", observed(), 64'(0));
    start = 1'b0;
    rst = 1'b0;
    for (int n = 0; n < NV; n++) run_cmd(vecs[n], n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tpu_seq.md
# tpu_seq

Sequencer for a DIM×DIM systolic array of MAC cells that shares one clock. It accepts a matrix-multiply command and optionally zeroes the accumulators through the cells' C-write path. It then drives the array enable while emitting skewed per-lane valid flags for the A and B operand feeders, and finally walks the result rows out under a valid/ready handshake. It owns no datapath: feeders, the Cin mux and the result mux key off its outputs.

## Interface
- DIM, 8, array rows and columns; must be ≥2
- K_W, 8, width of the k_len command field
- STEP_W, $clog2((1<<K_W)+2*DIM), width of the compute step counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe; accepted only in IDLE
- k_len  in  K_W  inner dimension K, sampled with start; 0 is legal
- clear_c  in  1  sampled with start; 1 zeroes the accumulators before compute
- feed_stall  in  1  feeders not ready; freezes compute
- rd_ready  in  1  result consumer ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the command completes
- mac_en  out  1  array enable
- c_wr_en  out  1  array C-write enable; Cin is forced to 0 externally
- c_row  out  $clog2(DIM)  row receiving C-write / readout row
- step  out  STEP_W  compute step index
- a_lane_valid  out  DIM  bit i: row-i feeder presents A[i][step−i], else drives 0
- b_lane_valid  out  DIM  bit j: column-j feeder presents B[step−j][j], else drives 0
- rd_valid  out  1  result row c_row is presented

## Operation
- States: IDLE, CLEAR, COMPUTE, DRAIN, DONE.
- IDLE: start=1 latches k_len and clear_c. The next state is CLEAR if clear_c=1, else COMPUTE if k_len≠0, else DRAIN.
- CLEAR: lasts DIM cycles, with c_wr_en=1 and c_row counting 0..DIM−1. Then go to COMPUTE if k_len≠0, else DRAIN.
- COMPUTE:
  - Total length L = k_len + 2·DIM − 2 non-stalled cycles. `step` counts 0..L−1.
  - mac_en = ¬feed_stall. This is the only combinational output path.
  - While feed_stall=1, `step` and the lane flags hold.
  - a_lane_valid[i] = (i ≤ step < i+k_len).
  - b_lane_valid[j] = (j ≤ step < j+k_len).
  - After step L−1 completes unstalled, go to DRAIN.
- DRAIN:
  - rd_valid=1 and c_row starts at 0.
  - c_row advances on rd_valid∧rd_ready.
  - After the handshake on row DIM−1, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- mac_en and c_wr_en are never high together, and never high outside COMPUTE and CLEAR respectively.
- start outside IDLE is ignored and does not alter the latched k_len or clear_c.
- k_len=0 with clear_c=1 yields a zeroed C readout. k_len=0 with clear_c=0 reads out the existing C.
- Step counter width rule: L−1 ≤ 2^K_W−1+2·DIM−3 must fit in STEP_W. No wrap-around is permitted.

## Timing
- Reset: state=IDLE. busy, done, mac_en, c_wr_en, rd_valid = 0. c_row=0, step=0, lane flags=0.
- Reset mid-operation aborts on the next edge with no done pulse. Accumulator contents are left undefined to the consumer.
- Start accepted at edge t puts the block in its first non-IDLE state during cycle t+1. busy rises in cycle t+1.
- With no stalls and rd_ready=1, latency from start to done is (clear_c·DIM) + L + DIM + 1 cycles.
- Lane flags and step are registered. They change only on unstalled COMPUTE edges.
- rd_valid stays high, and c_row stays stable, until the handshake completes.
- A new start is accepted in the IDLE cycle immediately after DONE.

## Test plan
- DIM=8, k_len=3, clear_c=1, no stalls, rd_ready=1, start at edge 0:
  - c_wr_en high in cycles 1–8 with c_row 0..7.
  - mac_en high in cycles 9–25 (L=17).
  - a_lane_valid[0] high for steps 0–2; a_lane_valid[7] high for steps 7–9.
  - rd_valid in cycles 26–33; done in cycle 34.
- Same command with feed_stall high for 4 cycles at step 5: step holds at 5, mac_en low for those 4 cycles, done is delayed to cycle 38, and lane flags are unchanged across the stall.
- k_len=0, clear_c=0: no c_wr_en and no mac_en. DRAIN starts in cycle 1 and done arrives in cycle 9.
- DRAIN with rd_ready low for 3 cycles on row 2: rd_valid stays high and c_row=2 is held; rows are still delivered 0..7 exactly once.
- start pulsed during COMPUTE with k_len=200: ignored, and the original L is preserved.
- rst asserted in COMPUTE at step 4: the next cycle shows state IDLE, all outputs 0, and no done pulse; a subsequent command behaves as from reset.
